fir_coeff_sequencer: RTL and testbench
======================================

Name: fir_coeff_sequencer

Overview:
- Control-side initiator for the reconfigurable FIR filter's coefficient RAM interface; it drives the filter's coefficient-update, memory-read, address and write-data inputs.
- Accepts 4 banks × NUM_TAPS coefficient words from a host over a valid/ready stream and packages them into coefficient-update write windows.
- On every 600 kHz sample strobe, issues the per-sample tap read burst for the selected bank.
- Sits between the host/config logic and the FIR datapath in the 12 MHz domain.

Parameters:
- NUM_TAPS, 10, taps per bank; legal range 1..14. Index NUM_TAPS+1 is the park index.
- WR_TAIL_CYC, 2, cycles the park address is held before oCoeffUpdateFlag drops.
- GUARD_CYC, 3, idle cycles after a write window before the FSM re-enters IDLE.

Ports:
- iClk12M  in  1  12 MHz clock.
- iRsn  in  1  asynchronous active-low reset.
- iEnSample600k  in  1  one-cycle sample strobe, every 20 clocks.
- iRdBank  in  2  bank to read; sampled when a read burst starts.
- iLoadReq  in  1  level request to load one bank; held until oLoadAck.
- iLoadBank  in  2  bank to load; sampled with oLoadAck.
- oLoadAck  out  1  one-cycle pulse when a load request is accepted.
- iCoeffValid  in  1  host coefficient word valid.
- iCoeffData  in  16  coefficient word.
- oCoeffReady  out  1  sequencer ready for a coefficient word.
- oCoeffUpdateFlag  out  1  write-window flag to the FIR.
- oMemRdFlag  out  1  read-window flag to the FIR.
- oAddrRam  out  6  {bank[1:0], idx[3:0]}.
- oWtDtRam  out  16  write data to the FIR.
- oBusy  out  1  FSM not in IDLE.
- oSampleMiss  out  1  one-cycle pulse when a sample strobe is dropped.

Behaviour:
- Reset: async on iRsn low. All outputs go to 0, the FSM goes to IDLE, and the pending flag and counters clear. Reset mid-burst aborts immediately; no tail or guard cycles are issued.
- All outputs are registered.
- FSM states: IDLE, WR_SETUP, WR_DATA, WR_TAIL, WR_GUARD, RD_SETUP, RD_ADDR, RD_TAIL.
- IDLE, priority 1: if iEnSample600k or the pending flag is set, latch iRdBank, clear pending, go to RD_SETUP, and set oMemRdFlag=1.
- IDLE, priority 2: else if iLoadReq, pulse oLoadAck, latch iLoadBank, go to WR_SETUP, and set oCoeffUpdateFlag=1.
- IDLE, same cycle: read wins; the load request stays asserted and is taken after the read.
- RD_SETUP: 1 cycle, then RD_ADDR.
- RD_ADDR: NUM_TAPS cycles. oAddrRam = {bank, 0..NUM_TAPS-1}, one index per cycle.
- RD_TAIL: 1 cycle. oAddrRam = {bank,4'h0} and oMemRdFlag=0; then IDLE.
- Read burst length: NUM_TAPS+2 cycles (12 for default), which fits inside the 20-cycle sample period.
- WR_SETUP: 1 cycle, then WR_DATA with oCoeffReady=1.
- WR_DATA handshake: on each cycle with iCoeffValid & oCoeffReady, register oAddrRam={bank,idx} and oWtDtRam=iCoeffData, then idx+1.
- WR_DATA stall: with no valid, outputs hold their last values and oCoeffUpdateFlag stays 1.
- WR_DATA exit: after word NUM_TAPS-1 is accepted, drop oCoeffReady and go to WR_TAIL.
- WR_TAIL: oAddrRam = {bank, NUM_TAPS+1} and oWtDtRam=0 for WR_TAIL_CYC cycles. Then oCoeffUpdateFlag=0 and go to WR_GUARD.
- WR_GUARD: GUARD_CYC cycles, then IDLE.
- Sample strobe outside IDLE (write or read in progress): set the pending flag.
- Sample strobe while pending is already set: pulse oSampleMiss; pending stays 1 (one-deep).
- oCoeffUpdateFlag and oMemRdFlag are never both 1.
- The idx counter is 4 bits and never wraps past NUM_TAPS-1.

Optional Feature:
- FIR_BANK_VALID_EN defined: keep a 4-bit loaded mask, cleared on reset. Set bit[bank] on RD/WR_TAIL entry after a complete load.
- With the macro, a read of an unloaded bank issues no burst, stays in IDLE, and pulses oSampleMiss.
- FIR_BANK_VALID_EN undefined: no mask; reads are always issued.

Test Plan:
- Reset then strobe, iRdBank=2 → oMemRdFlag=1 for 11 cycles. oAddrRam steps 0x20..0x29 on cycles 2..11, then 0x20 with flag 0; oSampleMiss=0.
- Load bank 1 with words 0xB00..0xB09, iCoeffValid continuous → oLoadAck pulse; oAddrRam 0x10..0x19 paired with oWtDtRam 0xB00..0xB09; then 0x1B/0x0000 for 2 cycles; flag low; oBusy low 3 cycles later.
- Same load with iCoeffValid low for 3 cycles after word 4 → addr 0x14 / data 0xB04 held, flag held, no extra word written.
- iEnSample600k asserted mid-write → read burst starts the cycle after WR_GUARD ends; two strobes during one write → exactly one oSampleMiss pulse.
- iLoadReq and strobe in the same IDLE cycle → read burst first; oLoadAck on the first IDLE cycle after RD_TAIL.
- iRsn pulsed low in RD_ADDR at idx 5 → all outputs 0 asynchronously; the next strobe starts a fresh burst at idx 0. With FIR_BANK_VALID_EN, a strobe with iRdBank=3 unloaded gives no burst and one oSampleMiss pulse.

Source files
------------

// File: rtl/fir_coeff_sequencer.sv
// Coefficient RAM sequencer for the reconfigurable FIR: host load windows and per-sample tap read bursts.
// Optional feature macro FIR_BANK_VALID_EN: track loaded banks and refuse reads of banks never loaded.
module fir_coeff_sequencer #(
  parameter int NUM_TAPS    = 10,
  parameter int WR_TAIL_CYC = 2,
  parameter int GUARD_CYC   = 3
) (
  input  logic        iClk12M,
  input  logic        iRsn,
  input  logic        iEnSample600k,
  input  logic [1:0]  iRdBank,
  input  logic        iLoadReq,
  input  logic [1:0]  iLoadBank,
  output logic        oLoadAck,
  input  logic        iCoeffValid,
  input  logic [15:0] iCoeffData,
  output logic        oCoeffReady,
  output logic        oCoeffUpdateFlag,
  output logic        oMemRdFlag,
  output logic [5:0]  oAddrRam,
  output logic [15:0] oWtDtRam,
  output logic        oBusy,
  output logic        oSampleMiss
);

  typedef enum logic [2:0] {
    IDLE, WR_SETUP, WR_DATA, WR_TAIL, WR_GUARD, RD_SETUP, RD_ADDR, RD_TAIL
  } seqStateT;

  localparam int               CNT_W      = 8;
  localparam logic [3:0]       LAST_IDX   = 4'(NUM_TAPS - 1);
  localparam logic [3:0]       PARK_IDX   = 4'(NUM_TAPS + 1);
  localparam logic [CNT_W-1:0] TAIL_LAST  = CNT_W'(WR_TAIL_CYC);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);

  seqStateT         state, stateNxt;
  logic [1:0]       bank, bankNxt;
  logic [3:0]       idx, idxNxt;
  logic [CNT_W-1:0] cnt, cntNxt;
  logic             pending, pendingNxt;
  logic [5:0]       addrNxt;
  logic [15:0]      wtDtNxt;
  logic             rdFlagNxt, updFlagNxt, readyNxt, loadAckNxt, missNxt;
  logic             rdBankOk;

`ifdef FIR_BANK_VALID_EN
  logic [3:0] loadedMask, loadedMaskNxt;
  assign rdBankOk = loadedMask[iRdBank];
`else
  assign rdBankOk = 1'b1;
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    stateNxt   = state;
    bankNxt    = bank;
    idxNxt     = idx;
    cntNxt     = cnt;
    pendingNxt = pending;
    addrNxt    = oAddrRam;
    wtDtNxt    = oWtDtRam;
    rdFlagNxt  = oMemRdFlag;
    updFlagNxt = oCoeffUpdateFlag;
    readyNxt   = oCoeffReady;
    loadAckNxt = 1'b0;
    missNxt    = 1'b0;
`ifdef FIR_BANK_VALID_EN
    loadedMaskNxt = loadedMask;
`endif

    // A strobe arriving mid-burst is remembered once; a second one is reported as dropped.
    if (state != IDLE && iEnSample600k) begin
      if (pending) missNxt = 1'b1;
      else         pendingNxt = 1'b1;
    end

    case (state)
      IDLE: begin
        if (iEnSample600k || pending) begin
          pendingNxt = 1'b0;
          if (iEnSample600k && pending) missNxt = 1'b1;
          if (!rdBankOk) begin
            missNxt = 1'b1;
          end else begin
            bankNxt   = iRdBank;
            stateNxt  = RD_SETUP;
            rdFlagNxt = 1'b1;
          end
        end else if (iLoadReq) begin
          loadAckNxt = 1'b1;
          bankNxt    = iLoadBank;
          stateNxt   = WR_SETUP;
          updFlagNxt = 1'b1;
        end
      end
      RD_SETUP: begin
        stateNxt = RD_ADDR;
        idxNxt   = 4'h0;
        addrNxt  = {bank, 4'h0};
      end
      RD_ADDR: begin
        if (idx == LAST_IDX) begin
          stateNxt  = RD_TAIL;
          addrNxt   = {bank, 4'h0};
          rdFlagNxt = 1'b0;
        end else begin
          idxNxt  = idx + 4'd1;
          addrNxt = {bank, idx + 4'd1};
        end
      end
      RD_TAIL: stateNxt = IDLE;
      WR_SETUP: begin
        stateNxt = WR_DATA;
        idxNxt   = 4'h0;
        readyNxt = 1'b1;
      end
      WR_DATA: begin
        if (iCoeffValid && oCoeffReady) begin
          addrNxt = {bank, idx};
          wtDtNxt = iCoeffData;
          if (idx == LAST_IDX) begin
            readyNxt = 1'b0;
            stateNxt = WR_TAIL;
            cntNxt   = '0;
`ifdef FIR_BANK_VALID_EN
            loadedMaskNxt[bank] = 1'b1;
`endif
          end else begin
            idxNxt = idx + 4'd1;
          end
        end
      end
      WR_TAIL: begin
        // First tail cycle still shows the last word; the park address follows for WR_TAIL_CYC cycles.
        addrNxt = {bank, PARK_IDX};
        wtDtNxt = 16'h0000;
        if (cnt == TAIL_LAST) begin
          updFlagNxt = 1'b0;
          stateNxt   = WR_GUARD;
          cntNxt     = '0;
        end else begin
          cntNxt = cnt + 1'b1;
        end
      end
      WR_GUARD: begin
        if (cnt == GUARD_LAST) stateNxt = IDLE;
        else                   cntNxt   = cnt + 1'b1;
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      state            <= IDLE;
      bank             <= 2'b00;
      idx              <= 4'h0;
      cnt              <= '0;
      pending          <= 1'b0;
      oAddrRam         <= 6'h00;
      oWtDtRam         <= 16'h0000;
      oMemRdFlag       <= 1'b0;
      oCoeffUpdateFlag <= 1'b0;
      oCoeffReady      <= 1'b0;
      oLoadAck         <= 1'b0;
      oSampleMiss      <= 1'b0;
      oBusy            <= 1'b0;
`ifdef FIR_BANK_VALID_EN
      loadedMask       <= 4'h0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      state            <= stateNxt;
      bank             <= bankNxt;
      idx              <= idxNxt;
      cnt              <= cntNxt;
      pending          <= pendingNxt;
      oAddrRam         <= addrNxt;
      oWtDtRam         <= wtDtNxt;
      oMemRdFlag       <= rdFlagNxt;
      oCoeffUpdateFlag <= updFlagNxt;
      oCoeffReady      <= readyNxt;
      oLoadAck         <= loadAckNxt;
      oSampleMiss      <= missNxt;
      oBusy            <= (stateNxt != IDLE);
`ifdef FIR_BANK_VALID_EN
      loadedMask       <= loadedMaskNxt;
`endif
    end
  end

endmodule

// File: tb/tb_fir_coeff_sequencer.sv
// Directed self-checking bench for fir_coeff_sequencer (default parameters).
// Covers reads, loads, stalls, pending strobes, arbitration, async reset and FIR_BANK_VALID_EN.
module tb_fir_coeff_sequencer;

  logic        iClk12M = 1'b0;
  logic        iRsn;
  logic        iEnSample600k;
  logic [1:0]  iRdBank;
  logic        iLoadReq;
  logic [1:0]  iLoadBank;
  logic        oLoadAck;
  logic        iCoeffValid;
  logic [15:0] iCoeffData;
  logic        oCoeffReady;
  logic        oCoeffUpdateFlag;
  logic        oMemRdFlag;
  logic [5:0]  oAddrRam;
  logic [15:0] oWtDtRam;
  logic        oBusy;
  logic        oSampleMiss;

  int checks = 0;
  int errors = 0;

  always #5 iClk12M = ~iClk12M;

  fir_coeff_sequencer dut (
    .iClk12M         (iClk12M),
    .iRsn            (iRsn),
    .iEnSample600k   (iEnSample600k),
    .iRdBank         (iRdBank),
    .iLoadReq        (iLoadReq),
    .iLoadBank       (iLoadBank),
    .oLoadAck        (oLoadAck),
    .iCoeffValid     (iCoeffValid),
    .iCoeffData      (iCoeffData),
    .oCoeffReady     (oCoeffReady),
    .oCoeffUpdateFlag(oCoeffUpdateFlag),
    .oMemRdFlag      (oMemRdFlag),
    .oAddrRam        (oAddrRam),
    .oWtDtRam        (oWtDtRam),
    .oBusy           (oBusy),
    .oSampleMiss     (oSampleMiss)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sample 1 ns after the active edge; flags must never overlap.
  task automatic tick();
    @(posedge iClk12M);
    #1;
    check("flags_exclusive", 32'(oMemRdFlag & oCoeffUpdateFlag), 0);
  endtask

  // Entered on the RD_SETUP display cycle; ends on the first IDLE display cycle.
  task automatic expect_read(input int bank);
    check("rd_setup_flag", 32'(oMemRdFlag), 1);
    check("rd_setup_busy", 32'(oBusy), 1);
    check("rd_setup_ack", 32'(oLoadAck), 0);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("rd_addr", 32'(oAddrRam), bank * 16 + k);
      check("rd_addr_flag", 32'(oMemRdFlag), 1);
      check("rd_addr_miss", 32'(oSampleMiss), 0);
      check("rd_addr_ack", 32'(oLoadAck), 0);
    end
    tick();
    check("rd_tail_addr", 32'(oAddrRam), bank * 16);
    check("rd_tail_flag", 32'(oMemRdFlag), 0);
    check("rd_tail_busy", 32'(oBusy), 1);
    tick();
    check("rd_idle_busy", 32'(oBusy), 0);
    check("rd_idle_ack", 32'(oLoadAck), 0);
  endtask

  // Full load of one bank; optional stall after word stallAfter and strobes at words strobeA/strobeB.
  task automatic load_bank(input int bank, input int base, input int stallAfter,
                           input int strobeA, input int strobeB);
    iLoadReq  = 1'b1;
    iLoadBank = 2'(bank);
    tick();
    check("ld_ack", 32'(oLoadAck), 1);
    check("ld_setup_flag", 32'(oCoeffUpdateFlag), 1);
    check("ld_setup_rdflag", 32'(oMemRdFlag), 0);
    check("ld_setup_busy", 32'(oBusy), 1);
    iLoadReq = 1'b0;
    tick();
    check("ld_ack_pulse", 32'(oLoadAck), 0);
    check("ld_ready", 32'(oCoeffReady), 1);
    for (int k = 0; k < 10; k++) begin
      iCoeffValid   = 1'b1;
      iCoeffData    = 16'(base + k);
      iEnSample600k = (k == strobeA || k == strobeB);
      tick();
      iEnSample600k = 1'b0;
      check("wr_addr", 32'(oAddrRam), bank * 16 + k);
      check("wr_data", 32'(oWtDtRam), base + k);
      check("wr_flag", 32'(oCoeffUpdateFlag), 1);
      check("wr_miss", 32'(oSampleMiss), (k == strobeB && strobeA >= 0) ? 1 : 0);
      check("wr_ready", 32'(oCoeffReady), (k == 9) ? 0 : 1);
      if (k == stallAfter) begin
        iCoeffValid = 1'b0;
        iCoeffData  = 16'hDEAD;
        for (int s = 0; s < 3; s++) begin
          tick();
          check("stall_addr", 32'(oAddrRam), bank * 16 + k);
          check("stall_data", 32'(oWtDtRam), base + k);
          check("stall_flag", 32'(oCoeffUpdateFlag), 1);
          check("stall_ready", 32'(oCoeffReady), 1);
        end
      end
    end
    iCoeffValid = 1'b0;
    for (int t = 0; t < 2; t++) begin
      tick();
      check("tail_addr", 32'(oAddrRam), bank * 16 + 11);
      check("tail_data", 32'(oWtDtRam), 0);
      check("tail_flag", 32'(oCoeffUpdateFlag), 1);
    end
    tick();
    check("guard_flag", 32'(oCoeffUpdateFlag), 0);
    check("guard_busy", 32'(oBusy), 1);
    for (int g = 0; g < 2; g++) begin
      tick();
      check("guard_busy_hold", 32'(oBusy), 1);
    end
    tick();
    check("ld_idle_busy", 32'(oBusy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    iRsn          = 1'b0;
    iEnSample600k = 1'b0;
    iRdBank       = 2'd0;
    iLoadReq      = 1'b0;
    iLoadBank     = 2'd0;
    iCoeffValid   = 1'b0;
    iCoeffData    = 16'h0000;
    repeat (3) @(posedge iClk12M);
    #1;
    check("rst_addr", 32'(oAddrRam), 0);
    check("rst_rdflag", 32'(oMemRdFlag), 0);
    check("rst_busy", 32'(oBusy), 0);
    check("rst_ready", 32'(oCoeffReady), 0);
    iRsn = 1'b1;
    tick();
    check("post_rst_busy", 32'(oBusy), 0);

`ifdef FIR_BANK_VALID_EN
    iRdBank       = 2'd3;
    iEnSample600k = 1'b1;
    tick();
    iEnSample600k = 1'b0;
    check("unloaded_miss", 32'(oSampleMiss), 1);
    check("unloaded_busy", 32'(oBusy), 0);
    check("unloaded_rdflag", 32'(oMemRdFlag), 0);
    tick();
    check("unloaded_miss_pulse", 32'(oSampleMiss), 0);
    load_bank(2, 16'hC00, -1, -1, -1);
`endif

    // Plain read burst of bank 2.
    iRdBank       = 2'd2;
    iEnSample600k = 1'b1;
    tick();
    iEnSample600k = 1'b0;
    expect_read(2);

    // Loads of bank 1: continuous, then with a 3-cycle stall after word 4.
    load_bank(1, 16'hB00, -1, -1, -1);
    load_bank(1, 16'hB00, 4, -1, -1);

    // Two strobes during one write: one miss, then the pending read follows.
    load_bank(2, 16'hC00, -1, 3, 6);
    iRdBank = 2'd1;
    tick();
    expect_read(1);

    // Simultaneous load request and strobe: read first, then the load.
    iLoadReq      = 1'b1;
    iLoadBank     = 2'd0;
    iRdBank       = 2'd1;
    iEnSample600k = 1'b1;
    tick();
    iEnSample600k = 1'b0;
    expect_read(1);
    load_bank(0, 16'hA00, -1, -1, -1);

    // Async reset in the middle of a read burst at idx 5.
    iRdBank       = 2'd2;
    iEnSample600k = 1'b1;
    tick();
    iEnSample600k = 1'b0;
    repeat (6) tick();
    check("pre_rst_addr", 32'(oAddrRam), 16'h25);
    #2;
    iRsn = 1'b0;
    #1;
    check("async_rst_addr", 32'(oAddrRam), 0);
    check("async_rst_rdflag", 32'(oMemRdFlag), 0);
    check("async_rst_busy", 32'(oBusy), 0);
    check("async_rst_data", 32'(oWtDtRam), 0);
    tick();
    check("rst_hold_addr", 32'(oAddrRam), 0);
    iRsn = 1'b1;
    tick();
    check("rst_no_pending", 32'(oBusy), 0);
    check("rst_no_pending_rd", 32'(oMemRdFlag), 0);
    iRdBank       = 2'd3;
    iEnSample600k = 1'b1;
    tick();
    iEnSample600k = 1'b0;
`ifdef FIR_BANK_VALID_EN
    check("rst_unloaded_miss", 32'(oSampleMiss), 1);
    check("rst_unloaded_busy", 32'(oBusy), 0);
`else
    expect_read(3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
